mc_ctrl: RTL
============

// Module: mc_ctrl
// PURPOSE
// Main controller for the multi-cycle MIPS datapath: ifu, register file, ALU, extender, and one shared instr/data memory port.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives every datapath enable and mux select.
// Supports addu, subu, ori, lui, lw, sw, beq, j, jal and jr. Illegal opcodes or a memory-port timeout halt the core with a fault code.
// PARAMETERS
// WAIT_LIMIT  16  max consecutive cycles waiting on MemReady in FETCH/MEM before fault; 0 disables the timeout
// PORTS
// Clk        in   1  clock, all state updates on posedge
// Reset      in   1  synchronous, active-high reset
// Opcode     in   6  IR[31:26], stable from the cycle after FETCH completes
// Funct      in   6  IR[5:0]
// Zero       in   1  ALU result == 0
// MemReady   in   1  memory port completes the current access this cycle
// MemReq     out  1  memory access request
// IorD       out  1  0 = address from PC (instr), 1 = address from ALU result (data)
// MemWr      out  1  data memory write strobe; valid only while MemReq=1
// IRWr       out  1  load IR from memory read data
// PCWr       out  1  PC write enable
// NPCSel     out  2  00 PC+4, 01 PC+(sext(imm)<<2), 10 {PC[31:28],instr_index,2'b00}, 11 rs (jr)
// RegWr      out  1  register file write enable
// RegDst     out  2  00 rt, 01 rd, 10 $31
// WDSel      out  2  00 ALU result, 01 memory data, 10 current PC (already PC+4 after fetch)
// ALUSrc     out  1  0 = rt value, 1 = extended immediate
// ExtOp      out  2  00 zero-extend, 01 sign-extend, 10 imm<<16 (lui)
// ALUOp      out  2  00 add, 01 sub, 10 or
// InstrDone  out  1  one-cycle pulse in the final cycle of each instruction
// Fault      out  2  00 none, 01 illegal instruction, 10 memory timeout; held until Reset
// BEHAVIOUR
// - State register is the only sequential state, plus a wait counter sized for WAIT_LIMIT. Outputs decode combinationally from state, Opcode, Funct, Zero and MemReady.
// - Reset: next state FETCH, wait counter 0, Fault 00. While Reset=1, every enable/strobe (MemReq, MemWr, IRWr, PCWr, RegWr, InstrDone) is forced 0.
// - Reset asserted mid-instruction aborts it with no further writes; FETCH is entered the cycle after Reset falls.
// - Outputs not listed for a state are 0. Select outputs take their 00 value when unused.
// - FETCH: MemReq=1, IorD=0. Stay here until MemReady=1; in that same cycle IRWr=1, PCWr=1, NPCSel=00 -> DECODE.
// - DECODE (register read):
//   - j: PCWr=1, NPCSel=10, InstrDone=1 -> FETCH.
//   - jal: as j, plus RegWr=1, RegDst=10, WDSel=10 -> FETCH.
//   - jr (op 0, funct 001000): PCWr=1, NPCSel=11, InstrDone=1 -> FETCH.
//   - beq: -> BRANCH.
//   - addu (funct 100001), subu (funct 100011), ori, lui, lw, sw: -> EXEC.
//   - Any other opcode, or op 0 with any other funct: -> HALT, Fault=01.
// - EXEC: ALU operation per instruction:
//   - addu: ALUOp=00, ALUSrc=0. subu: ALUOp=01, ALUSrc=0.
//   - ori: ALUOp=10, ALUSrc=1, ExtOp=00. lui: ALUOp=10, ALUSrc=1, ExtOp=10 (or with $0).
//   - lw/sw: ALUOp=00, ALUSrc=1, ExtOp=01.
//   - Next: lw/sw -> MEM; all others -> WB_ALU.
// - MEM: MemReq=1, IorD=1, MemWr=1 for sw. Keep ALU controls as in EXEC so the address stays stable. Stay here until MemReady=1; then sw raises InstrDone=1 -> FETCH, lw -> WB_MEM.
// - WB_ALU: RegWr=1, WDSel=00; RegDst=01 for R-type, 00 for ori/lui. ALU controls as in EXEC. InstrDone=1 -> FETCH.
// - WB_MEM: RegWr=1, RegDst=00, WDSel=01, InstrDone=1 -> FETCH.
// - BRANCH: ALUOp=01, ALUSrc=0. If Zero=1 then PCWr=1, NPCSel=01. InstrDone=1 -> FETCH.
// - HALT: all enables 0, no exit except Reset.
// - Cycles per instruction with MemReady tied high: j/jal/jr 2, beq 3, R-type/ori/lui/sw 4, lw 5.
// - Wait counter: increments each FETCH/MEM cycle with MemReady=0 and clears when MemReady=1 or on a state change. If WAIT_LIMIT>0 and the count reaches WAIT_LIMIT with MemReady still 0 -> HALT, Fault=10, and MemReq drops the next cycle.
// - MemReady arriving in the same cycle the count hits the limit counts as success (no fault).
// TESTING
// - Reset 1 cycle, MemReady=1, addu $3,$1,$2 -> states F,D,E,WB; RegWr=1, RegDst=01 in cycle 4 only; InstrDone pulses once.
// - lw with MemReady low 3 cycles in MEM -> MEM lasts 4 cycles, no RegWr until WB_MEM, then RegDst=00, WDSel=01.
// - beq with Zero=1 -> PCWr=1, NPCSel=01 in BRANCH; with Zero=0 -> PCWr=0, InstrDone still pulses.
// - jal -> DECODE asserts PCWr, NPCSel=10, RegWr, RegDst=10, WDSel=10 together; next state FETCH.
// - Opcode 6'b111111 -> HALT, Fault=01, all enables 0 for 20 cycles; Reset -> Fault=00, back in FETCH.
// - WAIT_LIMIT=4, MemReady stuck 0 in FETCH -> Fault=10 after 4 wait cycles; Reset asserted during MEM of sw -> MemWr=0 that cycle.

Source files
------------

// File: rtl/mc_ctrl.sv
// Main controller for the multi-cycle MIPS datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB and decodes every datapath enable and select.
module mc_ctrl #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       IorD,
    output logic       MemWr,
    output logic       IRWr,
    output logic       PCWr,
    output logic [1:0] NPCSel,
    output logic       RegWr,
    output logic [1:0] RegDst,
    output logic [1:0] WDSel,
    output logic       ALUSrc,
    output logic [1:0] ExtOp,
    output logic [1:0] ALUOp,
    output logic       InstrDone,
    output logic [1:0] Fault
);

    localparam int unsigned CW = (WAIT_LIMIT == 0) ? 1 : $clog2(WAIT_LIMIT + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;

    localparam logic [1:0] NPC_PC4 = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;
    localparam logic [1:0] DST_RT  = 2'b00;
    localparam logic [1:0] DST_RD  = 2'b01;
    localparam logic [1:0] DST_RA  = 2'b10;
    localparam logic [1:0] WD_ALU  = 2'b00;
    localparam logic [1:0] WD_MEM  = 2'b01;
    localparam logic [1:0] WD_PC   = 2'b10;
    localparam logic [1:0] EXT_Z   = 2'b00;
    localparam logic [1:0] EXT_S   = 2'b01;
    localparam logic [1:0] EXT_LUI = 2'b10;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_OR  = 2'b10;
    localparam logic [1:0] FLT_ILL = 2'b01;
    localparam logic [1:0] FLT_TMO = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC     = 4'd2,
        S_MEM      = 4'd3,
        S_WB_ALU   = 4'd4,
        S_WB_MEM   = 4'd5,
        S_BRANCH   = 4'd6,
        S_HALT_ILL = 4'd7,
        S_HALT_TMO = 4'd8
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_wait;

    logic            w_is_r;
    logic            w_is_addu;
    logic            w_is_subu;
    logic            w_is_jr;
    logic            w_is_ori;
    logic            w_is_lui;
    logic            w_is_lw;
    logic            w_is_sw;
    logic            w_is_mem;
    logic            w_to_exec;
    logic            w_wait_hit;
    logic [1:0]      w_alu_op;
    logic            w_alu_src;
    logic [1:0]      w_ext_op;

    assign w_is_r     = (Opcode == OP_RTYPE);
    assign w_is_addu  = w_is_r && (Funct == FN_ADDU);
    assign w_is_subu  = w_is_r && (Funct == FN_SUBU);
    assign w_is_jr    = w_is_r && (Funct == FN_JR);
    assign w_is_ori   = (Opcode == OP_ORI);
    assign w_is_lui   = (Opcode == OP_LUI);
    assign w_is_lw    = (Opcode == OP_LW);
    assign w_is_sw    = (Opcode == OP_SW);
    assign w_is_mem   = w_is_lw || w_is_sw;
    assign w_to_exec  = w_is_addu || w_is_subu || w_is_ori || w_is_lui || w_is_mem;
    // The count reaching the limit only faults if MemReady is still low in that cycle.
    assign w_wait_hit = (WAIT_LIMIT != 0) && (r_wait == CW'(WAIT_LIMIT));

    // ALU/extender controls shared by EXEC, MEM and WB_ALU so operands stay stable.
    always_comb begin
        w_alu_op  = ALU_ADD;
        w_alu_src = 1'b0;
        w_ext_op  = EXT_Z;
        if (w_is_subu) begin
            w_alu_op = ALU_SUB;
        end else if (w_is_ori) begin
            w_alu_op  = ALU_OR;
            w_alu_src = 1'b1;
        end else if (w_is_lui) begin
            w_alu_op  = ALU_OR;
            w_alu_src = 1'b1;
            w_ext_op  = EXT_LUI;
        end else if (w_is_mem) begin
            w_alu_src = 1'b1;
            w_ext_op  = EXT_S;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Memory wait counter: clears on completion or any state change.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wait <= '0;
        end else if (MemReady || (w_next != r_state)) begin
            r_wait <= '0;
        end else if ((WAIT_LIMIT != 0) && ((r_state == S_FETCH) || (r_state == S_MEM))) begin
            r_wait <= r_wait + CW'(1);
        end
    end

    always_comb begin
        w_next    = r_state;
        MemReq    = 1'b0;
        IorD      = 1'b0;
        MemWr     = 1'b0;
        IRWr      = 1'b0;
        PCWr      = 1'b0;
        NPCSel    = NPC_PC4;
        RegWr     = 1'b0;
        RegDst    = DST_RT;
        WDSel     = WD_ALU;
        ALUSrc    = 1'b0;
        ExtOp     = EXT_Z;
        ALUOp     = ALU_ADD;
        InstrDone = 1'b0;
        Fault     = 2'b00;

        case (r_state)
            S_FETCH: begin
                MemReq = 1'b1;
                if (MemReady) begin
                    IRWr   = 1'b1;
                    PCWr   = 1'b1;
                    w_next = S_DECODE;
                end else if (w_wait_hit) begin
                    w_next = S_HALT_TMO;
                end
            end
            S_DECODE: begin
                if (Opcode == OP_J) begin
                    PCWr      = 1'b1;
                    NPCSel    = NPC_J;
                    InstrDone = 1'b1;
                    w_next    = S_FETCH;
                end else if (Opcode == OP_JAL) begin
                    PCWr      = 1'b1;
                    NPCSel    = NPC_J;
                    RegWr     = 1'b1;
                    RegDst    = DST_RA;
                    WDSel     = WD_PC;
                    InstrDone = 1'b1;
                    w_next    = S_FETCH;
                end else if (w_is_jr) begin
                    PCWr      = 1'b1;
                    NPCSel    = NPC_JR;
                    InstrDone = 1'b1;
                    w_next    = S_FETCH;
                end else if (Opcode == OP_BEQ) begin
                    w_next = S_BRANCH;
                end else if (w_to_exec) begin
                    w_next = S_EXEC;
                end else begin
                    w_next = S_HALT_ILL;
                end
            end
            S_EXEC: begin
                ALUOp  = w_alu_op;
                ALUSrc = w_alu_src;
                ExtOp  = w_ext_op;
                w_next = w_is_mem ? S_MEM : S_WB_ALU;
            end
            S_MEM: begin
                MemReq = 1'b1;
                IorD   = 1'b1;
                MemWr  = w_is_sw;
                ALUOp  = w_alu_op;
                ALUSrc = w_alu_src;
                ExtOp  = w_ext_op;
                if (MemReady) begin
                    if (w_is_sw) begin
                        InstrDone = 1'b1;
                        w_next    = S_FETCH;
                    end else begin
                        w_next = S_WB_MEM;
                    end
                end else if (w_wait_hit) begin
                    w_next = S_HALT_TMO;
                end
            end
            S_WB_ALU: begin
                RegWr     = 1'b1;
                RegDst    = w_is_r ? DST_RD : DST_RT;
                ALUOp     = w_alu_op;
                ALUSrc    = w_alu_src;
                ExtOp     = w_ext_op;
                InstrDone = 1'b1;
                w_next    = S_FETCH;
            end
            S_WB_MEM: begin
                RegWr     = 1'b1;
                WDSel     = WD_MEM;
                InstrDone = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                ALUOp = ALU_SUB;
                if (Zero) begin
                    PCWr   = 1'b1;
                    NPCSel = NPC_BR;
                end
                InstrDone = 1'b1;
                w_next    = S_FETCH;
            end
            S_HALT_ILL: Fault = FLT_ILL;
            S_HALT_TMO: Fault = FLT_TMO;
            default:    w_next = S_FETCH;
        endcase

        // Reset suppresses every write so an aborted instruction leaves no side effects.
        if (Reset) begin
            MemReq    = 1'b0;
            MemWr     = 1'b0;
            IRWr      = 1'b0;
            PCWr      = 1'b0;
            RegWr     = 1'b0;
            InstrDone = 1'b0;
        end
    end

endmodule
